// File: rtl/riscv_branch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_branch_pkg : funct3 encodings and legality helper for conditional
//                    branches.
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic is_branch_legal(input logic [2:0] funct3);
    case (funct3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_cond_eval : combinational condition evaluation for the six
//                    conditional-branch types.
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_cond_eval
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            eq,
  output logic            lt,
  output logic            taken,
  output logic            illegal
);

  logic w_baseCond;

  assign eq         = (rs1 == rs2);
  // funct3[1] selects the unsigned flavour (BLTU/BGEU)
  assign lt         = funct3[1] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
  assign w_baseCond = funct3[2] ? lt : eq;
  assign illegal    = !is_branch_legal(funct3);
  assign taken      = !illegal && (w_baseCond ^ funct3[0]);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolve_unit : registered branch resolution with target adder,
//                       mispredict redirect, flush and saturating counters.
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import riscv_branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int INST_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  input  logic             clr_stats,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             br_eq,
  output logic             br_lt,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            w_eq;
  logic            w_lt;
  logic            w_taken;
  logic            w_illegal;
  logic            w_accept;
  logic            w_mispredict;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fallthrough;

  logic             r_outValid;
  logic             r_taken;
  logic             r_mispredict;
  logic [XLEN-1:0]  r_redirectPc;
  logic             r_brEq;
  logic             r_brLt;
  logic             r_illegal;
  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredCnt;

  branch_cond_eval #(
    .XLEN(XLEN)
  ) u_condEval (
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .eq     (w_eq),
    .lt     (w_lt),
    .taken  (w_taken),
    .illegal(w_illegal)
  );

  assign w_target      = pc + imm;
  assign w_fallthrough = pc + XLEN'(INST_BYTES);
  assign w_mispredict  = w_taken ^ pred_taken;

  // Single output slot: a consumed slot can be refilled on the same edge
  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid   <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_redirectPc <= '0;
      r_brEq       <= 1'b0;
      r_brLt       <= 1'b0;
      r_illegal    <= 1'b0;
      r_branchCnt  <= '0;
      r_mispredCnt <= '0;
    end else begin
      if (flush) begin
        r_outValid <= 1'b0;
      end else if (w_accept) begin
        r_outValid   <= 1'b1;
        r_taken      <= w_taken;
        r_mispredict <= w_mispredict;
        r_redirectPc <= w_taken ? w_target : w_fallthrough;
        r_brEq       <= w_eq;
        r_brLt       <= w_lt;
        r_illegal    <= w_illegal;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      // Clear beats a coincident accept
      if (clr_stats) begin
        r_branchCnt  <= '0;
        r_mispredCnt <= '0;
      end else if (w_accept) begin
        if (r_branchCnt != '1) begin
          r_branchCnt <= r_branchCnt + 1'b1;
        end
        if (w_mispredict && (r_mispredCnt != '1)) begin
          r_mispredCnt <= r_mispredCnt + 1'b1;
        end
      end
    end
  end

  assign out_valid   = r_outValid;
  assign taken       = r_taken;
  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirectPc;
  assign br_eq       = r_brEq;
  assign br_lt       = r_brLt;
  assign illegal     = r_illegal;
  assign branch_cnt  = r_branchCnt;
  assign mispred_cnt = r_mispredCnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit : scoreboard bench for branch_resolve_unit (CNT_W=2).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  rs1, rs2, pc, imm;
  logic [2:0]       funct3;
  logic             pred_taken, flush, clr_stats;
  logic             out_valid, out_ready;
  logic             taken, mispredict, br_eq, br_lt, illegal;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  typedef struct packed {
    logic        taken;
    logic        mispredict;
    logic [31:0] redirect;
    logic        eq;
    logic        lt;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   nVec  = 0;
  int   nMiss = 0;
  int   mBr   = 0;
  int   mMis  = 0;
  int   w1, w2;

  branch_resolve_unit #(
    .XLEN(XLEN), .CNT_W(CNT_W), .INST_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .clr_stats(clr_stats),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_eq(br_eq),
    .br_lt(br_lt), .illegal(illegal), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im, input logic pr);
    exp_t e;
    e.illegal = 1'b0;
    e.eq      = (a == b);
    case (f)
      3'b000: e.taken = (a == b);
      3'b001: e.taken = (a != b);
      3'b100: e.taken = ($signed(a) <  $signed(b));
      3'b101: e.taken = ($signed(a) >= $signed(b));
      3'b110: e.taken = (a <  b);
      3'b111: e.taken = (a >= b);
      default: begin e.taken = 1'b0; e.illegal = 1'b1; end
    endcase
    e.lt         = (f == 3'b110 || f == 3'b111) ? (a < b) : ($signed(a) < $signed(b));
    e.mispredict = e.taken ^ pr;
    e.redirect   = e.taken ? (p + im) : (p + 32'd4);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until the DUT accepts it
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] im, input logic pr,
                      output int waits);
    funct3 = f; rs1 = a; rs2 = b; pc = p; imm = im; pred_taken = pr;
    in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) break;
      waits++;
      if (waits > 20) begin
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    q.push_back(model(f, a, b, p, im, pr));
    if (clr_stats) begin
      mBr = 0; mMis = 0;
    end else begin
      if (mBr < 3) mBr++;
      if (model(f, a, b, p, im, pr).mispredict && mMis < 3) mMis++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("taken",      {31'd0, taken},      {31'd0, e.taken});
          chk("mispredict", {31'd0, mispredict}, {31'd0, e.mispredict});
          chk("redirect",   redirect_pc,         e.redirect);
          chk("br_eq",      {31'd0, br_eq},      {31'd0, e.eq});
          chk("br_lt",      {31'd0, br_lt},      {31'd0, e.lt});
          chk("illegal",    {31'd0, illegal},    {31'd0, e.illegal});
        end
      end
    end
  end

  task automatic chkCnt(input string tag);
    chk({tag, "_br"},  {30'd0, branch_cnt},  32'(mBr));
    chk({tag, "_mis"}, {30'd0, mispred_cnt}, 32'(mMis));
  endtask

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; funct3 = '0; pc = '0; imm = '0;
    pred_taken = 1'b0; flush = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid},  32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
    chk("rst_redirect",  redirect_pc,         32'd0);
    chk("rst_taken",     {31'd0, taken},      32'd0);
    chkCnt("rst_cnt");
    rst = 1'b0;
    tick();

    // Signed vs unsigned with the same operands
    send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, w1);
    chkCnt("blt_cnt");
    send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, w1);
    chkCnt("bltu_cnt");

    // Back-to-back with no bubble
    send(3'b000, 32'd5, 32'd5, 32'h300, 32'h40, 1'b1, w1);
    send(3'b001, 32'd5, 32'd5, 32'h300, 32'h40, 1'b1, w2);
    chk("b2b_wait", 32'(w2), 32'd0);
    tick();

    // Illegal funct3 and target wrap
    send(3'b010, 32'd9, 32'd9, 32'h400, 32'h10, 1'b1, w1);
    send(3'b000, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20, 1'b1, w1);
    send(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500, 32'hFFFF_FFF8, 1'b0, w1);
    send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500, 32'hFFFF_FFF8, 1'b1, w1);
    tick();

    // Backpressure: result held while the consumer stalls
    out_ready = 1'b0;
    send(3'b000, 32'd7, 32'd7, 32'h200, 32'h8, 1'b1, w1);
    fork
      send(3'b110, 32'd1, 32'd2, 32'h600, 32'h4, 1'b0, w2);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_rdy", {31'd0, in_ready},  32'd0);
          chk("stall_vld", {31'd0, out_valid}, 32'd1);
          chk("stall_pc",  redirect_pc,        32'h208);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    chk("stall_wait", 32'(w2 >= 3), 32'd1);
    tick();

    // Flush kills the pending result and the incoming request
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, 32'h700, 32'h4, 1'b0, w1);
    chkCnt("preflush_cnt");
    funct3 = 3'b001; rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    chkCnt("flush_cnt");
    q.delete();
    out_ready = 1'b1;
    tick();

    // Saturation of both counters
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    mBr = 0; mMis = 0;
    chkCnt("clr_cnt");
    for (int i = 0; i < 5; i++) begin
      send(3'b000, 32'(i), 32'(i + 1), 32'h800, 32'h10, 1'b1, w1);
    end
    chk("sat_mis", {30'd0, mispred_cnt}, 32'd3);
    chk("sat_br",  {30'd0, branch_cnt},  32'd3);

    // Clear coincident with accept leaves zero
    clr_stats = 1'b1;
    send(3'b001, 32'd1, 32'd2, 32'h900, 32'h10, 1'b0, w1);
    clr_stats = 1'b0;
    chkCnt("clr_accept");
    tick();

    // Asynchronous reset drops a pending result immediately
    out_ready = 1'b0;
    send(3'b001, 32'd1, 32'd2, 32'hA00, 32'h10, 1'b0, w1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld",  {31'd0, out_valid}, 32'd0);
    chk("arst_pc",   redirect_pc,        32'd0);
    chk("arst_br",   {30'd0, branch_cnt}, 32'd0);
    q.delete();
    mBr = 0; mMis = 0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'b100, 32'd2, 32'd3, 32'hB00, 32'h40, 1'b1, w1);
    chkCnt("post_rst_cnt");

    begin : drain
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
`default_nettype wire
